// File: rtl/work_packet_tx.sv
// UART transmitter for the miner work packet: latches one 416-bit job and sends it
// as 52 back-to-back 8N1 frames, most significant byte of midstate first.
module work_packet_tx #(
  parameter int baud_rate    = 9600,
  parameter int sys_clk_freq = 12000000
) (
  input  logic         comm_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  nonce_min,
  input  logic [31:0]  nonce_max,
  output logic         tx_serial,
  output logic         busy,
  output logic         done,
  output logic [5:0]   byte_index
);

  localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [5:0] LAST_BYTE = 6'd51;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("work_packet_tx: sys_clk_freq/baud_rate must be at least 2");
    end
  endgenerate

  logic [1:0]    state_reg;
  logic [CW-1:0] baud_reg;
  logic [2:0]    bit_reg;
  logic [415:0]  shift_reg;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_next;
  logic          baud_last;

  // The byte on the line always sits in the top 8 bits of the shift register.
  assign cur_byte  = shift_reg[415:408];
  assign bit_next  = bit_reg + 3'd1;
  assign baud_last = (baud_reg == BAUD_LAST);

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      tx_serial  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_index <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_reg <= {midstate, work_data, nonce_min, nonce_max};
            state_reg <= START;
            baud_reg  <= '0;
            tx_serial <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (baud_last) begin
            baud_reg  <= '0;
            bit_reg   <= '0;
            tx_serial <= cur_byte[0];
            state_reg <= DATA;
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (bit_reg == 3'd7) begin
              tx_serial <= 1'b1;
              state_reg <= STOP;
            end else begin
              bit_reg   <= bit_next;
              tx_serial <= cur_byte[bit_next];
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_reg <= '0;
            if (byte_index == LAST_BYTE) begin
              state_reg  <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              byte_index <= '0;
              tx_serial  <= 1'b1;
            end else begin
              // Next start bit follows the stop bit directly, no idle gap.
              byte_index <= byte_index + 6'd1;
              shift_reg  <= {shift_reg[407:0], 8'h00};
              tx_serial  <= 1'b0;
              state_reg  <= START;
            end
          end else begin
            baud_reg <= baud_reg + CW'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_work_packet_tx.sv
// Bench for work_packet_tx: a 4 clk/bit instance decoded by a sampling UART receiver,
// plus a default-rate instance whose bit widths are measured directly.
module tb_work_packet_tx;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // fast instance (4 clocks per bit)
  logic         reset_a, start_a;
  logic [255:0] ms_a;
  logic [95:0]  wd_a;
  logic [31:0]  nmin_a, nmax_a;
  logic         tx_a, busy_a, done_a;
  logic [5:0]   bi_a;

  // default-rate instance (1250 clocks per bit)
  logic         reset_b, start_b;
  logic [255:0] ms_b;
  logic [95:0]  wd_b;
  logic [31:0]  nmin_b, nmax_b;
  logic         tx_b, busy_b, done_b;
  logic [5:0]   bi_b;

  work_packet_tx #(.baud_rate(1), .sys_clk_freq(4)) dut_a (
    .comm_clk(clk), .reset(reset_a), .start(start_a),
    .midstate(ms_a), .work_data(wd_a), .nonce_min(nmin_a), .nonce_max(nmax_a),
    .tx_serial(tx_a), .busy(busy_a), .done(done_a), .byte_index(bi_a)
  );

  work_packet_tx dut_b (
    .comm_clk(clk), .reset(reset_b), .start(start_b),
    .midstate(ms_b), .work_data(wd_b), .nonce_min(nmin_b), .nonce_max(nmax_b),
    .tx_serial(tx_b), .busy(busy_b), .done(done_b), .byte_index(bi_b)
  );

  typedef struct {
    logic [255:0] ms;
    logic [95:0]  wd;
    logic [31:0]  nmin;
    logic [31:0]  nmax;
    logic [7:0]   exp_b0;
    logic [7:0]   exp_b48;
    logic [7:0]   exp_b51;
  } vec_t;

  vec_t vecs [3];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int vi);
    ms_a   = vecs[vi].ms;
    wd_a   = vecs[vi].wd;
    nmin_a = vecs[vi].nmin;
    nmax_a = vecs[vi].nmax;
  endtask

  function automatic logic [7:0] exp_byte(input int vi, input int k);
    logic [415:0] pkt;
    pkt = {vecs[vi].ms, vecs[vi].wd, vecs[vi].nmin, vecs[vi].nmax};
    return pkt[415 - 8*k -: 8];
  endfunction

  // Sends vector vi and decodes it at mid-bit. With hold, start stays high the whole
  // packet and the buses switch to vector nvi mid-flight; start is left high on return.
  task automatic run_packet(input int vi, input bit hold, input int nvi, input string tag);
    int start_bad, stop_bad, idx_bad, busy_bad, done_cnt, k, pos, b;
    logic [5:0] bi_final;
    logic [7:0] rx [52];
    start_bad = 0; stop_bad = 0; idx_bad = 0; busy_bad = 0; done_cnt = 0;
    bi_final = '0;
    apply(vi);
    start_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 2080; c++) begin
      if (c == 0 && !hold) start_a = 1'b0;
      if (hold && c == 100) apply(nvi);
      if (done_a === 1'b1) done_cnt++;
      if (c < 2080) begin
        if (busy_a !== 1'b1) busy_bad++;
        if (c == 0 && tx_a !== 1'b0) start_bad++;
        k = c / 40;
        pos = c % 40;
        if (pos % 4 == 2) begin
          b = pos / 4;
          if (bi_a !== 6'(k)) idx_bad++;
          if (b == 0) begin
            if (tx_a !== 1'b0) start_bad++;
          end else if (b == 9) begin
            if (tx_a !== 1'b1) stop_bad++;
          end else begin
            rx[k][b-1] = tx_a;
          end
        end
        if (c == 51*40 + 20) bi_final = bi_a;
        @(negedge clk);
      end
    end
    check({tag, " done_at_2080"}, 64'(done_a), 64'd1);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " busy_clear"}, 64'(busy_a), 64'd0);
    check({tag, " idle_index"}, 64'(bi_a), 64'd0);
    check({tag, " tx_idle"}, 64'(tx_a), 64'd1);
    check({tag, " start_bits_bad"}, 64'(start_bad), 64'd0);
    check({tag, " stop_bits_bad"}, 64'(stop_bad), 64'd0);
    check({tag, " index_bad"}, 64'(idx_bad), 64'd0);
    check({tag, " busy_bad"}, 64'(busy_bad), 64'd0);
    check({tag, " index_final_frame"}, 64'(bi_final), 64'd51);
    check({tag, " byte0_hand"}, 64'(rx[0]), 64'(vecs[vi].exp_b0));
    check({tag, " byte48_hand"}, 64'(rx[48]), 64'(vecs[vi].exp_b48));
    check({tag, " byte51_hand"}, 64'(rx[51]), 64'(vecs[vi].exp_b51));
    for (int j = 0; j < 52; j++)
      check($sformatf("%s byte%0d", tag, j), 64'(rx[j]), 64'(exp_byte(vi, j)));
    $display("packet %s: vector %0d, 52 bytes decoded", tag, vi);
  endtask

  initial begin
    int w, bad_tx, bad_busy, dcnt;

    vecs[0] = '{ms: {2{128'h00112233445566778899AABBCCDDEEFF}},
                wd: 96'hA5A5A5A5_5A5A5A5A_0F0F0F0F,
                nmin: 32'h00000000, nmax: 32'hFFFFFFFF,
                exp_b0: 8'h00, exp_b48: 8'hFF, exp_b51: 8'hFF};
    vecs[1] = '{ms: 256'h0, wd: 96'h0,
                nmin: 32'h12345678, nmax: 32'h80000001,
                exp_b0: 8'h00, exp_b48: 8'h80, exp_b51: 8'h01};
    vecs[2] = '{ms: {8'hC3, 248'h0}, wd: 96'h0102030405060708090A0B0C,
                nmin: 32'hDEADBEEF, nmax: 32'h7F00FF00,
                exp_b0: 8'hC3, exp_b48: 8'h7F, exp_b51: 8'h00};

    reset_a = 1'b1; start_a = 1'b1; apply(0);
    reset_b = 1'b1; start_b = 1'b0;
    ms_b = {8'h01, 248'h0}; wd_b = '0; nmin_b = '0; nmax_b = '0;

    // reset held 3 cycles with start high
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d tx", i), 64'(tx_a), 64'd1);
      check($sformatf("reset%0d busy", i), 64'(busy_a), 64'd0);
      check($sformatf("reset%0d done", i), 64'(done_a), 64'd0);
      check($sformatf("reset%0d index", i), 64'(bi_a), 64'd0);
    end
    reset_a = 1'b0; start_a = 1'b0; reset_b = 1'b0;
    bad_tx = 0; bad_busy = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx_a !== 1'b1) bad_tx++;
      if (busy_a !== 1'b0) bad_busy++;
    end
    check("post_reset no_start_bit", 64'(bad_tx), 64'd0);
    check("post_reset not_busy", 64'(bad_busy), 64'd0);
    $display("reset: outputs idle, no start bit followed");

    // table-driven packets
    for (int v = 0; v < 3; v++) run_packet(v, 1'b0, 0, $sformatf("vec%0d", v));

    // start held through a packet, buses changed mid-flight, back-to-back second packet
    run_packet(0, 1'b1, 2, "hold_first");
    run_packet(2, 1'b0, 0, "back_to_back");

    // reset in the middle of byte 17, data bit 3
    apply(1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (17*40 + 17) @(negedge clk);
    check("midreset pre_index", 64'(bi_a), 64'd17);
    check("midreset pre_busy", 64'(busy_a), 64'd1);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    check("midreset tx", 64'(tx_a), 64'd1);
    check("midreset busy", 64'(busy_a), 64'd0);
    check("midreset index", 64'(bi_a), 64'd0);
    check("midreset done", 64'(done_a), 64'd0);
    dcnt = 0; bad_tx = 0;
    repeat (2100) begin
      @(negedge clk);
      if (done_a !== 1'b0) dcnt++;
      if (tx_a !== 1'b1) bad_tx++;
    end
    check("midreset no_done", 64'(dcnt), 64'd0);
    check("midreset line_idle", 64'(bad_tx), 64'd0);
    $display("mid-packet reset: packet abandoned, no done");
    run_packet(1, 1'b0, 0, "after_reset");

    // default rate: start bit and first data bit widths
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    w = 0;
    while (tx_b === 1'b0 && w < 5000) begin w++; @(negedge clk); end
    check("default start_bit_width", 64'(w), 64'd1250);
    w = 0;
    while (tx_b === 1'b1 && w < 5000) begin w++; @(negedge clk); end
    check("default data_bit0_width", 64'(w), 64'd1250);
    check("default busy", 64'(busy_b), 64'd1);
    check("default index", 64'(bi_b), 64'd0);
    $display("default rate: start and bit0 widths measured");
    reset_b = 1'b1;
    @(negedge clk);
    reset_b = 1'b0;
    check("default reset tx", 64'(tx_b), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
